i2c_slave_regs: RTL and testbench
=================================

Name: i2c_slave_regs

Overview:
- I2C target (responder) for the same 7-bit-address, 8-bit-sub-address protocol that the on-board I2C master drives. Typical use is loop-back verification and an FPGA-side register bank on the DE2-115.
- SCL and SDA are oversampled on clk_50. The block detects START and STOP conditions, ACKs its own address and presents a simple register read/write strobe interface to user logic.
- The sub-address auto-increments on every data byte. No clock stretching.

Parameters:
- SLAVE_ADDR, 7'h3C, 7-bit bus address this block answers to.

Ports:
- clk_50  input  1  system clock, 50 MHz.
- reset_n  input  1  asynchronous active-low reset.
- SCL  input  1  I2C clock, input only; this block never drives SCL.
- SDA  inout  1  I2C data, open-drain: driven 0 or 1'bZ.
- reg_addr  output  8  current sub-address pointer.
- reg_wdata  output  8  received data byte; valid while reg_wr=1.
- reg_wr  output  1  one-cycle write strobe.
- reg_rd  output  1  one-cycle read request.
- reg_rdata  input  8  read data for reg_addr. Sampled exactly 2 clk_50 cycles after reg_rd.
- busy  output  1  high from a START that carries a matching address until STOP, mismatch or reset.
- nack_rx  output  1  one-cycle pulse when the master NACKs a read byte.

Behaviour:
- Reset (async, reset_n=0):
  - State goes to IDLE; SDA is released (Z).
  - reg_addr=0, reg_wdata=0, reg_wr=0, reg_rd=0, busy=0, nack_rx=0.
  - Shift register, bit counter and synchronisers are cleared to 1 for SCL/SDA.
  - Reset mid-transfer releases SDA immediately. The block ignores the bus until the next START.
- Input conditioning:
  - SCL and SDA each pass through a 2-FF synchroniser plus one history FF.
  - scl_rise, scl_fall, sda_rise and sda_fall are single-cycle pulses, 3 cycles after the pin edge.
- Bus conditions:
  - START: sda_fall while synced SCL=1. This forces state ADDR and bit_cnt=0 from any state, which covers repeated START.
  - STOP: sda_rise while synced SCL=1. This forces IDLE from any state, releases SDA and clears busy.
  - START and STOP take priority over data-bit handling in the same cycle.
- Bit timing:
  - Data is sampled on scl_rise, MSB first.
  - SDA drive changes only on scl_fall.
  - bit_cnt is 4 bits, 0..8. Bit 8 is the ACK slot.
- States: IDLE, ADDR, SUB, WDATA, RDATA, IGNORE.
  - IDLE: SDA released. Waits for START.
  - ADDR: shifts 8 bits on rising edges.
    - After the 8th rise, compares bits[7:1] to SLAVE_ADDR.
    - On match, drives SDA=0 on the following scl_fall (ACK) and sets busy=1. It releases SDA on the next scl_fall after the ACK rise.
    - R/W=0 goes to SUB. R/W=1 pulses reg_rd, latches reg_rdata 2 cycles later, then goes to RDATA.
    - On mismatch, goes to IGNORE; SDA is never driven.
  - SUB: shifts 8 bits, loads reg_addr, ACKs, then goes to WDATA.
  - WDATA: shifts 8 bits. On the 8th rise:
    - reg_wdata gets the byte and reg_wr pulses 1 cycle with the current reg_addr.
    - Then reg_addr increments, wrapping 8'hFF to 8'h00.
    - The byte is ACKed and the state stays WDATA.
  - RDATA: drives tx_shift[7] on each scl_fall, with bit 7 valid at the first fall after the ACK.
    - After the 8th bit, SDA is released on scl_fall.
    - The master's ACK/NACK is sampled on the 9th rise; reg_addr increments (with wrap) either way.
    - ACK(0): pulse reg_rd, reload tx_shift, continue.
    - NACK(1): pulse nack_rx, go to IGNORE.
  - IGNORE: SDA released. Leaves only on START (to ADDR) or STOP (to IDLE).
- A repeated START after SUB keeps reg_addr, so a write-sub-address-then-read sequence works.
- SDA is driven low only during ACK slots or when tx bit = 0; otherwise it is Z.
- Supported SCL up to 400 kHz.

Test Plan:
- Write: START, 0x78 (addr 0x3C W), 0x10, 0xA5, 0x5A, STOP -> ACK on all 4 bytes. reg_wr pulses twice: (addr 0x10, data 0xA5), (0x11, 0x5A). Final reg_addr=0x12, busy=0 after STOP.
- Read with repeated START: START, 0x78, 0x20, Sr, 0x79; master ACKs 2 bytes then NACKs the 3rd. reg_rdata = 0x80|reg_addr -> SDA returns 0xA0, 0xA1, 0xA2. nack_rx pulses once; reg_addr=0x23.
- Address mismatch: START, 0x50, 0x10, 0x55, STOP -> SDA never driven low by the block, no reg_wr/reg_rd, busy stays 0.
- Wrap: write at sub-address 0xFF with data 0x01, 0x02 -> reg_wr at 0xFF then 0x00.
- Abort: STOP after 4 bits of a WDATA byte -> no reg_wr, IDLE, SDA released. Repeat with reset_n=0 mid-RDATA while driving 0 -> SDA=Z within the reset, all outputs at reset values.

Source files
------------

// File: rtl/i2c_slave_regs_if.sv
// Register-side strobe interface between the I2C target and the user register bank.
interface i2c_slave_regs_if;
    logic [7:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_wr;
    logic       reg_rd;
    logic [7:0] reg_rdata;
    logic       busy;
    logic       nack_rx;

    modport slave (
        output reg_addr, reg_wdata, reg_wr, reg_rd, busy, nack_rx,
        input  reg_rdata
    );

    modport master (
        input  reg_addr, reg_wdata, reg_wr, reg_rd, busy, nack_rx,
        output reg_rdata
    );
endinterface

// File: rtl/i2c_slave_regs.sv
// I2C target: 7-bit address, 8-bit auto-incrementing sub-address, strobe register port.
// SCL/SDA are oversampled on clk_50; SDA is open-drain and never stretched.
module i2c_slave_regs #(
    parameter logic [6:0] SLAVE_ADDR = 7'h3C
) (
    input  logic            clk_50,
    input  logic            reset_n,
    input  logic            SCL,
    inout  wire             SDA,
    i2c_slave_regs_if.slave bus
);
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ADDR   = 3'd1,
        ST_SUB    = 3'd2,
        ST_WDATA  = 3'd3,
        ST_RDATA  = 3'd4,
        ST_IGNORE = 3'd5
    } state_t;

    logic       scl_s1_q, scl_s2_q, scl_h_q;
    logic       sda_s1_q, sda_s2_q, sda_h_q;
    state_t     state_q, state_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic [6:0] rx_shift_q, rx_shift_d;
    logic [7:0] tx_shift_q, tx_shift_d;
    logic       sda_oe_q, sda_oe_d;
    logic       rd_dly_q, rd_dly_d;
    logic [7:0] reg_addr_q, reg_addr_d;
    logic [7:0] reg_wdata_q, reg_wdata_d;
    logic       reg_wr_q, reg_wr_d;
    logic       reg_rd_q, reg_rd_d;
    logic       busy_q, busy_d;
    logic       nack_rx_q, nack_rx_d;

    logic       scl_rise_s, scl_fall_s, sda_rise_s, sda_fall_s;
    logic       start_s, stop_s;
    logic [7:0] rx_byte_s;

    assign SDA = sda_oe_q ? 1'b0 : 1'bz;

    // Two-stage synchronisers plus one history stage per bus line.
    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            scl_s1_q <= 1'b1;
            scl_s2_q <= 1'b1;
            scl_h_q  <= 1'b1;
            sda_s1_q <= 1'b1;
            sda_s2_q <= 1'b1;
            sda_h_q  <= 1'b1;
        end else begin
            scl_s1_q <= SCL;
            scl_s2_q <= scl_s1_q;
            scl_h_q  <= scl_s2_q;
            sda_s1_q <= SDA;
            sda_s2_q <= sda_s1_q;
            sda_h_q  <= sda_s2_q;
        end
    end

    assign scl_rise_s = scl_s2_q & ~scl_h_q;
    assign scl_fall_s = ~scl_s2_q & scl_h_q;
    assign sda_rise_s = sda_s2_q & ~sda_h_q;
    assign sda_fall_s = ~sda_s2_q & sda_h_q;
    assign start_s    = sda_fall_s & scl_s2_q;
    assign stop_s     = sda_rise_s & scl_s2_q;
    assign rx_byte_s  = {rx_shift_q, sda_s2_q};

    // Protocol engine next-state decode; bus START/STOP override bit handling.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        rx_shift_d  = rx_shift_q;
        tx_shift_d  = rd_dly_q ? bus.reg_rdata : tx_shift_q;
        sda_oe_d    = sda_oe_q;
        rd_dly_d    = reg_rd_q;
        reg_addr_d  = reg_wr_q ? (reg_addr_q + 8'd1) : reg_addr_q;
        reg_wdata_d = reg_wdata_q;
        reg_wr_d    = 1'b0;
        reg_rd_d    = 1'b0;
        busy_d      = busy_q;
        nack_rx_d   = 1'b0;

        if (stop_s) begin
            state_d   = ST_IDLE;
            bit_cnt_d = 4'd0;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b0;
        end else if (start_s) begin
            state_d   = ST_ADDR;
            bit_cnt_d = 4'd0;
            sda_oe_d  = 1'b0;
        end else begin
            case (state_q)
                ST_ADDR, ST_SUB, ST_WDATA: begin
                    if (scl_rise_s && (bit_cnt_q < 4'd8)) begin
                        rx_shift_d = rx_byte_s[6:0];
                        bit_cnt_d  = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            case (state_q)
                                ST_ADDR: begin
                                    if (rx_byte_s[7:1] == SLAVE_ADDR) begin
                                        busy_d   = 1'b1;
                                        reg_rd_d = rx_byte_s[0];
                                    end else begin
                                        busy_d  = 1'b0;
                                        state_d = ST_IGNORE;
                                    end
                                end
                                ST_SUB:  reg_addr_d = rx_byte_s;
                                default: begin
                                    reg_wdata_d = rx_byte_s;
                                    reg_wr_d    = 1'b1;
                                end
                            endcase
                        end else begin
                            reg_wr_d = 1'b0;
                        end
                    end else if (scl_rise_s) begin
                        // ACK-slot rise: the header's R/W bit selects the data phase
                        bit_cnt_d = 4'd0;
                        case (state_q)
                            ST_ADDR: state_d = rx_shift_q[0] ? ST_RDATA : ST_SUB;
                            default: state_d = ST_WDATA;
                        endcase
                    end else if (scl_fall_s) begin
                        sda_oe_d = (bit_cnt_q == 4'd8);
                    end else begin
                        sda_oe_d = sda_oe_q;
                    end
                end
                ST_RDATA: begin
                    if (scl_rise_s && (bit_cnt_q < 4'd8)) begin
                        tx_shift_d = {tx_shift_q[6:0], 1'b1};
                        bit_cnt_d  = bit_cnt_q + 4'd1;
                    end else if (scl_rise_s) begin
                        bit_cnt_d  = 4'd0;
                        reg_addr_d = reg_addr_q + 8'd1;
                        if (sda_s2_q) begin
                            nack_rx_d = 1'b1;
                            state_d   = ST_IGNORE;
                        end else begin
                            reg_rd_d = 1'b1;
                        end
                    end else if (scl_fall_s) begin
                        sda_oe_d = (bit_cnt_q < 4'd8) && !tx_shift_q[7];
                    end else begin
                        sda_oe_d = sda_oe_q;
                    end
                end
                default: begin
                    sda_oe_d  = 1'b0;
                    bit_cnt_d = 4'd0;
                end
            endcase
        end
    end

    // FSM state, datapath and registered outputs.
    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= 4'd0;
            rx_shift_q  <= 7'd0;
            tx_shift_q  <= 8'd0;
            sda_oe_q    <= 1'b0;
            rd_dly_q    <= 1'b0;
            reg_addr_q  <= 8'd0;
            reg_wdata_q <= 8'd0;
            reg_wr_q    <= 1'b0;
            reg_rd_q    <= 1'b0;
            busy_q      <= 1'b0;
            nack_rx_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_shift_q  <= rx_shift_d;
            tx_shift_q  <= tx_shift_d;
            sda_oe_q    <= sda_oe_d;
            rd_dly_q    <= rd_dly_d;
            reg_addr_q  <= reg_addr_d;
            reg_wdata_q <= reg_wdata_d;
            reg_wr_q    <= reg_wr_d;
            reg_rd_q    <= reg_rd_d;
            busy_q      <= busy_d;
            nack_rx_q   <= nack_rx_d;
        end
    end

    assign bus.reg_addr  = reg_addr_q;
    assign bus.reg_wdata = reg_wdata_q;
    assign bus.reg_wr    = reg_wr_q;
    assign bus.reg_rd    = reg_rd_q;
    assign bus.busy      = busy_q;
    assign bus.nack_rx   = nack_rx_q;
endmodule

// File: tb/tb_i2c_slave_regs.sv
// Directed bench for i2c_slave_regs: bit-banged I2C master, transaction-level
// expectation model and a per-cycle monitor on the register strobes.
module tb_i2c_slave_regs;
    localparam int Q = 200;   // quarter SCL period = 10 clk_50 cycles

    logic clk_50 = 1'b0;
    logic reset_n;
    logic scl_r;
    logic m_low;
    wire  sda_w;

    assign sda_w = m_low ? 1'b0 : 1'bz;
    pullup (sda_w);

    i2c_slave_regs_if bus_if ();

    i2c_slave_regs #(.SLAVE_ADDR(7'h3C)) dut (
        .clk_50 (clk_50),
        .reset_n(reset_n),
        .SCL    (scl_r),
        .SDA    (sda_w),
        .bus    (bus_if.slave)
    );

    always #10 clk_50 = ~clk_50;

    int vectors = 0;
    int miscompares = 0;

    // transaction-level expectations
    int          m_phase = 4;   // 0 header, 1 sub-address, 2 write data, 3 read data, 4 idle/ignored
    logic [7:0]  m_ptr = 8'd0;
    logic        m_busy = 1'b0;
    int          m_rd_exp = 0;
    int          m_nack_exp = 0;
    logic [15:0] wr_q[$];

    // observations
    int          wr_seen = 0;
    int          rd_seen = 0;
    int          nack_seen = 0;
    int          dut_low_cnt = 0;
    logic [15:0] last_wr = 16'd0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // User-side register bank: value 0x80|addr, presented only in the cycle it must be sampled.
    logic       rd_h1 = 1'b0;
    logic [7:0] rd_addr_h = 8'd0;
    always @(negedge clk_50) begin
        bus_if.reg_rdata = rd_h1 ? (8'h80 | rd_addr_h) : 8'h00;
        rd_h1 = bus_if.reg_rd;
        if (bus_if.reg_rd) rd_addr_h = bus_if.reg_addr;
    end

    // Per-cycle monitor of strobes and SDA ownership.
    always @(negedge clk_50) begin
        logic [15:0] exp_wr;
        if (reset_n) begin
            if (bus_if.reg_wr) begin
                wr_seen++;
                last_wr = {bus_if.reg_addr, bus_if.reg_wdata};
                if (wr_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL wr_unexpected: got %h expected no write", last_wr);
                end else begin
                    exp_wr = wr_q.pop_front();
                    check("wr_addr_data", last_wr, exp_wr);
                end
            end
            if (bus_if.reg_rd)  rd_seen++;
            if (bus_if.nack_rx) nack_seen++;
            if (!m_low && (sda_w == 1'b0)) dut_low_cnt++;
        end
    end

    task automatic bit_write(input logic b);
        m_low = ~b; #Q; scl_r = 1'b1; #(2*Q); scl_r = 1'b0; #Q;
    endtask

    task automatic bit_read(output logic b);
        m_low = 1'b0; #Q; scl_r = 1'b1; #Q; b = sda_w; #Q; scl_r = 1'b0; #Q;
    endtask

    task automatic i2c_start();
        m_low = 1'b0; #Q; scl_r = 1'b1; #Q; m_low = 1'b1; #Q; scl_r = 1'b0; #Q;
        m_phase = 0;
    endtask

    task automatic i2c_stop();
        scl_r = 1'b0; m_low = 1'b1; #Q; scl_r = 1'b1; #Q; m_low = 1'b0; #(2*Q);
        m_busy = 1'b0;
        m_phase = 4;
    endtask

    task automatic mwrite(input logic [7:0] b);
        logic exp_ack, ack_bit;
        case (m_phase)
            0: begin
                exp_ack = (b[7:1] == 7'h3C);
                m_busy  = exp_ack;
                m_phase = exp_ack ? (b[0] ? 3 : 1) : 4;
                if (exp_ack && b[0]) m_rd_exp++;
            end
            1: begin exp_ack = 1'b1; m_ptr = b; m_phase = 2; end
            2: begin exp_ack = 1'b1; wr_q.push_back({m_ptr, b}); m_ptr = m_ptr + 8'd1; end
            default: exp_ack = 1'b0;
        endcase
        for (int i = 7; i >= 0; i--) bit_write(b[i]);
        bit_read(ack_bit);
        check("ack", {15'd0, ~ack_bit}, {15'd0, exp_ack});
        check("busy", {15'd0, bus_if.busy}, {15'd0, m_busy});
        check("addr_ptr", {8'd0, bus_if.reg_addr}, {8'd0, m_ptr});
    endtask

    task automatic mread(input logic master_ack, output logic [7:0] got);
        logic [7:0] exp;
        logic       b;
        exp = 8'h80 | m_ptr;
        for (int i = 7; i >= 0; i--) begin
            bit_read(b);
            got[i] = b;
        end
        bit_write(~master_ack);
        m_ptr = m_ptr + 8'd1;
        if (master_ack) m_rd_exp++;
        else begin m_nack_exp++; m_phase = 4; end
        check("rd_data", {8'd0, got}, {8'd0, exp});
        check("rd_addr_ptr", {8'd0, bus_if.reg_addr}, {8'd0, m_ptr});
    endtask

    task automatic end_scenario();
        check("wr_pending", 16'(wr_q.size()), 16'd0);
        check("rd_count", 16'(rd_seen), 16'(m_rd_exp));
        check("nack_count", 16'(nack_seen), 16'(m_nack_exp));
        check("busy_end", {15'd0, bus_if.busy}, {15'd0, m_busy});
    endtask

    task automatic check_reset_outputs();
        check("rst_sda", {15'd0, sda_w}, 16'd1);
        check("rst_addr", {8'd0, bus_if.reg_addr}, 16'd0);
        check("rst_wdata", {8'd0, bus_if.reg_wdata}, 16'd0);
        check("rst_wr", {15'd0, bus_if.reg_wr}, 16'd0);
        check("rst_rd", {15'd0, bus_if.reg_rd}, 16'd0);
        check("rst_busy", {15'd0, bus_if.busy}, 16'd0);
        check("rst_nack", {15'd0, bus_if.nack_rx}, 16'd0);
    endtask

    initial begin
        logic [7:0] g0, g1, g2;
        logic       b;
        int         low0, wr0, rd0;

        reset_n = 1'b0;
        scl_r   = 1'b1;
        m_low   = 1'b0;
        #45;
        check_reset_outputs();
        #100 reset_n = 1'b1;
        #(4*Q);

        // Write burst: sub-address 0x10, two data bytes
        i2c_start();
        mwrite(8'h78); mwrite(8'h10); mwrite(8'hA5); mwrite(8'h5A);
        i2c_stop();
        end_scenario();
        check("wr_final_addr", {8'd0, bus_if.reg_addr}, 16'h0012);
        check("wr_last", last_wr, 16'h115A);
        check("wr_count", 16'(wr_seen), 16'd2);

        // Sub-address write, repeated START, three reads (ACK, ACK, NACK)
        i2c_start();
        mwrite(8'h78); mwrite(8'h20);
        i2c_start();
        mwrite(8'h79);
        mread(1'b1, g0); mread(1'b1, g1); mread(1'b0, g2);
        i2c_stop();
        end_scenario();
        check("rd_b0", {8'd0, g0}, 16'h00A0);
        check("rd_b1", {8'd0, g1}, 16'h00A1);
        check("rd_b2", {8'd0, g2}, 16'h00A2);
        check("rd_final_addr", {8'd0, bus_if.reg_addr}, 16'h0023);
        check("nack_once", 16'(nack_seen), 16'd1);

        // Foreign address: block must stay silent
        low0 = dut_low_cnt; wr0 = wr_seen; rd0 = rd_seen;
        i2c_start();
        mwrite(8'h50); mwrite(8'h10); mwrite(8'h55);
        i2c_stop();
        end_scenario();
        check("mm_sda_low", 16'(dut_low_cnt - low0), 16'd0);
        check("mm_wr", 16'(wr_seen - wr0), 16'd0);
        check("mm_rd", 16'(rd_seen - rd0), 16'd0);

        // Sub-address wrap 0xFF -> 0x00
        i2c_start();
        mwrite(8'h78); mwrite(8'hFF); mwrite(8'h01); mwrite(8'h02);
        i2c_stop();
        end_scenario();
        check("wrap_last", last_wr, 16'h0002);
        check("wrap_addr", {8'd0, bus_if.reg_addr}, 16'h0001);

        // STOP after four bits of a data byte
        wr0 = wr_seen;
        i2c_start();
        mwrite(8'h78); mwrite(8'h40);
        bit_write(1'b1); bit_write(1'b1); bit_write(1'b0); bit_write(1'b0);
        i2c_stop();
        end_scenario();
        check("abort_wr", 16'(wr_seen - wr0), 16'd0);
        check("abort_sda", {15'd0, sda_w}, 16'd1);
        check("abort_addr", {8'd0, bus_if.reg_addr}, 16'h0040);

        // Reset while the block drives a 0 data bit (0xB0, bit 6)
        i2c_start();
        mwrite(8'h78); mwrite(8'h30);
        i2c_start();
        mwrite(8'h79);
        bit_read(b);
        check("rst_rd_b7", {15'd0, b}, 16'd1);
        check("rst_pre_sda", {15'd0, sda_w}, 16'd0);
        reset_n = 1'b0;
        #1;
        check_reset_outputs();
        m_ptr = 8'd0; m_busy = 1'b0; m_phase = 4;
        #99 reset_n = 1'b1;
        #(2*Q);
        i2c_stop();
        end_scenario();
        check("post_rst_addr", {8'd0, bus_if.reg_addr}, 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
